// File: rtl/cva6_dmem_adapter_if.sv
// Bus bundle for the CVA6 data-RAM front end: CPU request/response plus RAM-side port.
// slave = adapter view, master = CPU + RAM view.
interface cva6_dmem_adapter_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        ram_req;
    logic        ram_we;
    logic [3:0]  ram_be;
    logic [11:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport slave (
        input  req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output ram_req, ram_we, ram_be, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output req_valid, req_addr, req_we, req_size, req_unsigned, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  ram_req, ram_we, ram_be, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/cva6_dmem_adapter.sv
// Byte-addressed load/store front end for the 4 KB data RAM: range check, misaligned split
// into two word beats, load alignment/extension into a held response.
module cva6_dmem_adapter #(
    parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
    parameter int unsigned SIZE_BYTES = 4096
) (
    input logic clk,
    input logic rst,
    cva6_dmem_adapter_if.slave bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] BEAT0 = 3'd1;
    localparam logic [2:0] BEAT1 = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] RESP  = 3'd4;

    localparam logic [32:0] LAST_ADDR = {1'b0, BASE_ADDR} + 33'(SIZE_BYTES) - 33'd1;

    logic [2:0]  state;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  b_q;
    logic        split_q;
    logic [9:0]  w_q;
    logic [3:0]  be_hi_q;
    logic [31:0] wdata_hi_q;
    logic [31:0] lo_q;

    logic [2:0]  nbytes;
    logic [3:0]  mask;
    logic [32:0] addr33;
    logic [32:0] end33;
    logic        bad;
    logic [11:0] off;
    logic [7:0]  m8;
    logic [63:0] d64;

    always_comb begin
        nbytes = 3'd0;
        mask   = 4'b0000;
        case (bus.req_size)
            2'b00:   begin nbytes = 3'd1; mask = 4'b0001; end
            2'b01:   begin nbytes = 3'd2; mask = 4'b0011; end
            2'b10:   begin nbytes = 3'd4; mask = 4'b1111; end
            default: begin nbytes = 3'd0; mask = 4'b0000; end
        endcase
    end

    // 33-bit math so a request near 0xFFFF_FFFF cannot wrap back into the window.
    assign addr33 = {1'b0, bus.req_addr};
    assign end33  = addr33 + {30'b0, nbytes} - 33'd1;
    assign bad    = (addr33 < {1'b0, BASE_ADDR}) || (end33 > LAST_ADDR) || (bus.req_size == 2'b11);
    assign off    = bus.req_addr[11:0] - BASE_ADDR[11:0];
    assign m8     = {4'b0000, mask} << off[1:0];
    assign d64    = {32'b0, bus.req_wdata} << {off[1:0], 3'b000};

    assign bus.req_ready = (state == IDLE) && !rst;

    logic [63:0] rd64;
    logic [31:0] aligned;
    logic [31:0] load_val;

    always_comb begin
        rd64    = split_q ? {bus.ram_rdata, lo_q} : {32'b0, bus.ram_rdata};
        aligned = 32'(rd64 >> {b_q, 3'b000});
        case (size_q)
            2'b00:   load_val = uns_q ? {24'b0, aligned[7:0]}  : {{24{aligned[7]}}, aligned[7:0]};
            2'b01:   load_val = uns_q ? {16'b0, aligned[15:0]} : {{16{aligned[15]}}, aligned[15:0]};
            default: load_val = aligned;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.ram_req   <= 1'b0;
            bus.ram_we    <= 1'b0;
            bus.ram_be    <= 4'b0000;
            bus.ram_addr  <= 12'd0;
            bus.ram_wdata <= 32'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= 32'd0;
            we_q          <= 1'b0;
            size_q        <= 2'b00;
            uns_q         <= 1'b0;
            b_q           <= 2'b00;
            split_q       <= 1'b0;
            w_q           <= 10'd0;
            be_hi_q       <= 4'b0000;
            wdata_hi_q    <= 32'd0;
            lo_q          <= 32'd0;
        end else begin
            bus.ram_req <= 1'b0;
            bus.ram_we  <= 1'b0;
            bus.ram_be  <= 4'b0000;
            case (state)
                IDLE: if (bus.req_valid) begin
                    we_q       <= bus.req_we;
                    size_q     <= bus.req_size;
                    uns_q      <= bus.req_unsigned;
                    b_q        <= off[1:0];
                    split_q    <= (m8[7:4] != 4'b0000);
                    w_q        <= off[11:2];
                    be_hi_q    <= m8[7:4];
                    wdata_hi_q <= d64[63:32];
                    if (bad) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_rdata <= 32'd0;
                    end else begin
                        state         <= BEAT0;
                        bus.ram_req   <= 1'b1;
                        bus.ram_we    <= bus.req_we;
                        bus.ram_be    <= m8[3:0];
                        bus.ram_addr  <= {2'b00, off[11:2]};
                        bus.ram_wdata <= d64[31:0];
                    end
                end
                BEAT0: begin
                    if (split_q) begin
                        state         <= BEAT1;
                        bus.ram_req   <= 1'b1;
                        bus.ram_we    <= we_q;
                        bus.ram_be    <= be_hi_q;
                        bus.ram_addr  <= {2'b00, w_q + 10'd1};
                        bus.ram_wdata <= wdata_hi_q;
                    end else begin
                        state <= WAIT;
                    end
                end
                BEAT1: begin
                    lo_q  <= bus.ram_rdata;
                    state <= WAIT;
                end
                WAIT: begin
                    state         <= RESP;
                    bus.rsp_valid <= 1'b1;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_rdata <= we_q ? 32'd0 : load_val;
                end
                RESP: if (bus.rsp_ready) begin
                    state         <= IDLE;
                    bus.rsp_valid <= 1'b0;
                    bus.rsp_err   <= 1'b0;
                    bus.rsp_rdata <= 32'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cva6_dmem_adapter.sv
// Scoreboard bench for cva6_dmem_adapter with a byte-enable RAM model behind it.
module tb_cva6_dmem_adapter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cva6_dmem_adapter_if bus ();

    cva6_dmem_adapter #(
        .BASE_ADDR (32'h1000_0000),
        .SIZE_BYTES(4096)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          acc;
        string       nm;
    } exp_t;

    typedef struct {
        logic [11:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        int          cyc;
    } beat_t;

    exp_t  exp_q[$];
    beat_t beat_q[$];
    int    n_chk = 0;
    int    n_fail = 0;
    int    cyc = 0;
    int    last_acc = 0;
    int    first_cyc = 0;
    logic  prev_vld = 1'b0;
    logic [31:0] mem [1024];

    always @(posedge clk) cyc <= cyc + 1;

    // Write-first RAM: one-cycle registered read, per-byte enables.
    always @(posedge clk) begin
        if (bus.ram_req) begin
            logic [31:0] nw;
            nw = mem[bus.ram_addr[9:0]];
            if (bus.ram_we) begin
                for (int i = 0; i < 4; i++)
                    if (bus.ram_be[i]) nw[i*8 +: 8] = bus.ram_wdata[i*8 +: 8];
            end
            mem[bus.ram_addr[9:0]] <= nw;
            bus.ram_rdata <= nw;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.ram_req)
            beat_q.push_back('{bus.ram_addr, bus.ram_be, bus.ram_wdata, bus.ram_we, cyc});
        if (bus.rsp_valid && !prev_vld) first_cyc = cyc;
        prev_vld = bus.rsp_valid;
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp: got rdata %h err %b expected no response",
                         bus.rsp_rdata, bus.rsp_err);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.nm, "_rdata"}, bus.rsp_rdata, e.rdata);
                chk({e.nm, "_err"}, {31'b0, bus.rsp_err}, {31'b0, e.err});
                chk({e.nm, "_lat"}, 32'(first_cyc - e.acc), 32'(e.lat));
            end
        end
    end

    task automatic issue(input string nm, input logic [31:0] addr, input logic we,
                         input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                         input logic do_push, input logic [31:0] erd, input logic eerr,
                         input int elat);
        int n;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_ready_timeout: req_ready stayed 0 for %0d cycles, required 1", nm, n);
        end
        @(posedge clk);
        #1;
        bus.req_valid    = 1'b1;
        bus.req_addr     = addr;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_wdata    = wdata;
        @(negedge clk);
        last_acc = cyc;
        if (do_push) exp_q.push_back('{erd, eerr, elat, cyc, nm});
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_rsp_timeout: %0d responses outstanding, required 0", nm, exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string nm, input int idx, input logic [11:0] addr,
                            input logic [3:0] be, input logic [31:0] wdata, input logic we);
        chk({nm, "_addr"}, {20'b0, beat_q[idx].addr}, {20'b0, addr});
        chk({nm, "_be"}, {28'b0, beat_q[idx].be}, {28'b0, be});
        chk({nm, "_wdata"}, beat_q[idx].wdata, wdata);
        chk({nm, "_we"}, {31'b0, beat_q[idx].we}, {31'b0, we});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_wdata    = 32'd0;
        bus.rsp_ready    = 1'b1;
        bus.ram_rdata    = 32'd0;

        repeat (2) @(negedge clk);
        chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_ram_req", {31'b0, bus.ram_req}, 32'd0);
        chk("rst_ram_we", {31'b0, bus.ram_we}, 32'd0);
        chk("rst_ram_be", {28'b0, bus.ram_be}, 32'd0);
        chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Aligned word store then loads of every width/sign.
        beat_q.delete();
        issue("st_word", 32'h1000_0010, 1'b1, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b1, 32'h0, 1'b0, 3);
        drain("st_word");
        chk("st_word_nbeats", 32'(beat_q.size()), 32'd1);
        chk_beat("st_word_b0", 0, 12'd4, 4'b1111, 32'hDEAD_BEEF, 1'b1);
        chk("st_word_b0_cyc", 32'(beat_q[0].cyc), 32'(last_acc + 1));

        issue("ld_word", 32'h1000_0010, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3);
        issue("ld_sbyte", 32'h1000_0013, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFDE, 1'b0, 3);
        issue("ld_ubyte", 32'h1000_0013, 1'b0, 2'b00, 1'b1, 32'h0, 1'b1, 32'h0000_00DE, 1'b0, 3);
        issue("ld_shalf", 32'h1000_0012, 1'b0, 2'b01, 1'b0, 32'h0, 1'b1, 32'hFFFF_DEAD, 1'b0, 3);
        issue("ld_uhalf", 32'h1000_0010, 1'b0, 2'b01, 1'b1, 32'h0, 1'b1, 32'h0000_BEEF, 1'b0, 3);
        drain("loads");

        // Misaligned word store straddling words 1 and 2.
        beat_q.delete();
        issue("st_mis", 32'h1000_0006, 1'b1, 2'b10, 1'b0, 32'h1122_3344, 1'b1, 32'h0, 1'b0, 4);
        drain("st_mis");
        chk("st_mis_nbeats", 32'(beat_q.size()), 32'd2);
        chk_beat("st_mis_b0", 0, 12'd1, 4'b1100, 32'h3344_0000, 1'b1);
        chk_beat("st_mis_b1", 1, 12'd2, 4'b0011, 32'h0000_1122, 1'b1);
        chk("st_mis_b1_cyc", 32'(beat_q[1].cyc), 32'(last_acc + 2));
        issue("ld_mis", 32'h1000_0006, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1, 32'h1122_3344, 1'b0, 4);
        issue("ld_mis_half", 32'h1000_0007, 1'b0, 2'b01, 1'b0, 32'h0, 1'b1, 32'h0000_2233, 1'b0, 4);
        drain("ld_mis");

        // Last byte of the window is legal.
        issue("st_top", 32'h1000_0FFF, 1'b1, 2'b00, 1'b0, 32'h0000_00A5, 1'b1, 32'h0, 1'b0, 3);
        issue("ld_top_s", 32'h1000_0FFF, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFA5, 1'b0, 3);
        issue("ld_top_u", 32'h1000_0FFF, 1'b0, 2'b00, 1'b1, 32'h0, 1'b1, 32'h0000_00A5, 1'b0, 3);
        drain("top");

        // Errors: never touch the RAM.
        beat_q.delete();
        issue("err_above", 32'h1000_1000, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        issue("err_straddle", 32'h1000_0FFE, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        issue("err_size", 32'h1000_0000, 1'b0, 2'b11, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        issue("err_below", 32'h0FFF_FFFF, 1'b0, 2'b00, 1'b0, 32'h0, 1'b1, 32'h0, 1'b1, 1);
        issue("err_st_top", 32'h1000_0FFE, 1'b1, 2'b10, 1'b0, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, 1);
        drain("errors");
        chk("err_nbeats", 32'(beat_q.size()), 32'd0);

        // Response held under backpressure.
        bus.rsp_ready = 1'b0;
        issue("ld_stall", 32'h1000_0010, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 3);
        begin
            int n;
            n = 0;
            while (!bus.rsp_valid && n < 20) begin
                @(negedge clk);
                n++;
            end
        end
        for (int i = 0; i < 5; i++) begin
            chk("stall_rsp_valid", {31'b0, bus.rsp_valid}, 32'd1);
            chk("stall_rsp_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
            chk("stall_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
            chk("stall_req_ready", {31'b0, bus.req_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("stall_hs_req_ready", {31'b0, bus.req_ready}, 32'd0);
        @(negedge clk);
        chk("stall_after_req_ready", {31'b0, bus.req_ready}, 32'd1);
        drain("stall");

        // Reset during BEAT0 of a split store: beat 1 is dropped.
        beat_q.delete();
        issue("st_rst", 32'h1000_0006, 1'b1, 2'b10, 1'b0, 32'hAABB_CCDD, 1'b0, 32'h0, 1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_beat0_ram_req", {31'b0, bus.ram_req}, 32'd1);
        @(negedge clk);
        chk("rst_mid_ram_req", {31'b0, bus.ram_req}, 32'd0);
        chk("rst_mid_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
        chk("rst_mid_req_ready", {31'b0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rel_req_ready", {31'b0, bus.req_ready}, 32'd1);
        repeat (4) @(negedge clk);
        chk("rst_nbeats", 32'(beat_q.size()), 32'd1);
        chk_beat("rst_b0", 0, 12'd1, 4'b1100, 32'hCCDD_0000, 1'b1);
        @(posedge clk);
        #1;
        issue("ld_partial", 32'h1000_0006, 1'b0, 2'b10, 1'b0, 32'h0, 1'b1, 32'h1122_CCDD, 1'b0, 4);
        drain("ld_partial");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
